// File: rtl/hazard_stall_controller_pkg.sv
// Shared types for the hazard/stall controller: memory-wait FSM states
// and the hard-wired zero register specifier.
package hazard_stall_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_TIMEOUT = 2'd2
    } hsc_state_e;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_stall_controller_stall_stat_counter.sv
// Saturating statistics counter with increment enable.
// Holds at all-ones once full.
module stall_stat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hold/flush/bubble control for load-use, ID branches and memory waits.
// Define HAZARD_STALL_STATS_EN to build the saturating statistics counters.
import hazard_stall_controller_pkg::*;

module hazard_stall_controller #(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 255,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] ID_rs,
    input  logic [REG_ADDR_W-1:0] ID_rt,
    input  logic                  ID_use_rs,
    input  logic                  ID_use_rt,
    input  logic [REG_ADDR_W-1:0] EX_rt,
    input  logic                  EX_mem_read,
    input  logic                  ID_branch_taken,
    input  logic                  MEM_req,
    input  logic                  MEM_ready,
    output logic                  PC_stall,
    output logic                  IFID_stall,
    output logic                  IFID_flush,
    output logic                  IDEX_bubble,
    output logic                  pipe_freeze,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      load_use_cnt,
    output logic [CNT_W-1:0]      mem_wait_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    hsc_state_e    state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;

    logic load_use;
    logic mem_wait;
    logic timed_out;

    assign load_use = EX_mem_read
                    && (EX_rt != REG_ADDR_W'(REG_ZERO))
                    && (((EX_rt == ID_rs) && ID_use_rs)
                     || ((EX_rt == ID_rt) && ID_use_rt));
    assign mem_wait  = MEM_req && !MEM_ready;
    assign timed_out = (state_q == ST_TIMEOUT);

    // The counter already counts the cycle that enters WAIT, so the
    // MAX_WAIT-th consecutive wait cycle sees WAIT_LAST.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            ST_TIMEOUT: begin
                state_d = ST_TIMEOUT;
            end
            ST_RUN, ST_WAIT: begin
                if (!mem_wait) begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WAIT_LAST) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    state_d = ST_WAIT;
                    wcnt_d  = wcnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        PC_stall    = 1'b0;
        IFID_stall  = 1'b0;
        IFID_flush  = 1'b0;
        IDEX_bubble = 1'b0;
        pipe_freeze = 1'b0;
        mem_timeout = 1'b0;
        if (reset) begin
            PC_stall = 1'b0;
        end else if (timed_out) begin
            pipe_freeze = 1'b1;
            PC_stall    = 1'b1;
            IFID_stall  = 1'b1;
            mem_timeout = 1'b1;
        end else if (mem_wait) begin
            pipe_freeze = 1'b1;
            PC_stall    = 1'b1;
            IFID_stall  = 1'b1;
        end else if (load_use) begin
            PC_stall    = 1'b1;
            IFID_stall  = 1'b1;
            IDEX_bubble = 1'b1;
        end else if (ID_branch_taken) begin
            IFID_flush  = 1'b1;
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    logic lu_inc, mw_inc, fl_inc;

    assign mw_inc = !reset && !timed_out && mem_wait;
    assign lu_inc = !reset && !timed_out && !mem_wait && load_use;
    assign fl_inc = !reset && !timed_out && !mem_wait && !load_use
                  && ID_branch_taken;

    stall_stat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lu_inc),
        .cnt   (load_use_cnt)
    );

    stall_stat_counter #(.CNT_W(CNT_W)) u_mw_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mw_inc),
        .cnt   (mem_wait_cnt)
    );

    stall_stat_counter #(.CNT_W(CNT_W)) u_fl_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (fl_inc),
        .cnt   (flush_cnt)
    );
`else
    assign load_use_cnt = '0;
    assign mem_wait_cnt = '0;
    assign flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with MAX_WAIT=4.
module tb_hazard_stall_controller;

`ifdef HAZARD_STALL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // {PC_stall, IFID_stall, IFID_flush, IDEX_bubble, pipe_freeze, mem_timeout}
    localparam logic [5:0] NONE   = 6'b000000;
    localparam logic [5:0] STALL  = 6'b110100;
    localparam logic [5:0] FLUSH  = 6'b001000;
    localparam logic [5:0] FREEZE = 6'b110010;
    localparam logic [5:0] TOUT   = 6'b110011;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, EX_rt;
    logic        ID_use_rs, ID_use_rt, EX_mem_read;
    logic        ID_branch_taken, MEM_req, MEM_ready;
    logic        PC_stall, IFID_stall, IFID_flush;
    logic        IDEX_bubble, pipe_freeze, mem_timeout;
    logic [31:0] load_use_cnt, mem_wait_cnt, flush_cnt;
    logic [5:0]  o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(
        .REG_ADDR_W (5),
        .MAX_WAIT   (4),
        .CNT_W      (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ID_rs           (ID_rs),
        .ID_rt           (ID_rt),
        .ID_use_rs       (ID_use_rs),
        .ID_use_rt       (ID_use_rt),
        .EX_rt           (EX_rt),
        .EX_mem_read     (EX_mem_read),
        .ID_branch_taken (ID_branch_taken),
        .MEM_req         (MEM_req),
        .MEM_ready       (MEM_ready),
        .PC_stall        (PC_stall),
        .IFID_stall      (IFID_stall),
        .IFID_flush      (IFID_flush),
        .IDEX_bubble     (IDEX_bubble),
        .pipe_freeze     (pipe_freeze),
        .mem_timeout     (mem_timeout),
        .load_use_cnt    (load_use_cnt),
        .mem_wait_cnt    (mem_wait_cnt),
        .flush_cnt       (flush_cnt)
    );

    assign o = {PC_stall, IFID_stall, IFID_flush,
                IDEX_bubble, pipe_freeze, mem_timeout};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        ID_rs = 5'd0; ID_rt = 5'd0; EX_rt = 5'd0;
        ID_use_rs = 1'b0; ID_use_rt = 1'b0; EX_mem_read = 1'b0;
        ID_branch_taken = 1'b0; MEM_req = 1'b0; MEM_ready = 1'b0;
    endtask

    task automatic ld_use_rs5;
        EX_mem_read = 1'b1; EX_rt = 5'd5;
        ID_rs = 5'd5; ID_use_rs = 1'b1;
    endtask

    task automatic chk_cnts(input string tag, input int lu,
                            input int mw, input int fl);
        chk({tag, "_lu_cnt"}, load_use_cnt, STATS ? lu : 0);
        chk({tag, "_mw_cnt"}, mem_wait_cnt, STATS ? mw : 0);
        chk({tag, "_fl_cnt"}, flush_cnt,    STATS ? fl : 0);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        ld_use_rs5();
        MEM_req = 1'b1;
        #1;
        chk("reset_outs", o, NONE);
        cyc();
        cyc();
        chk("reset_outs_held", o, NONE);
        chk_cnts("reset", 0, 0, 0);
        idle();
        reset = 1'b0;
        #1;
        chk("idle", o, NONE);

        // load-use on rs, one cycle only
        cyc();
        ld_use_rs5();
        #1;
        chk("lu_rs", o, STALL);
        cyc();
        EX_mem_read = 1'b0;
        #1;
        chk("lu_rs_gone", o, NONE);

        // r0 destination never stalls
        cyc();
        EX_mem_read = 1'b1; EX_rt = 5'd0; ID_rs = 5'd0; ID_use_rs = 1'b1;
        #1;
        chk("lu_r0", o, NONE);

        // rt match only counts when rt is read
        cyc();
        idle();
        EX_mem_read = 1'b1; EX_rt = 5'd7; ID_rt = 5'd7;
        #1;
        chk("lu_rt_unused", o, NONE);
        ID_use_rt = 1'b1;
        #1;
        chk("lu_rt", o, STALL);

        cyc();
        idle();
        ID_branch_taken = 1'b1;
        #1;
        chk("branch", o, FLUSH);
        cyc();
        ld_use_rs5();
        #1;
        chk("branch_vs_lu", o, STALL);
        cyc();
        idle();
        #1;
        chk("after_branch", o, NONE);
        chk_cnts("s1", 3, 0, 1);

        // ready in the first request cycle: no freeze
        MEM_req = 1'b1; MEM_ready = 1'b1;
        #1;
        chk("mem_fast", o, NONE);

        // 3-cycle wait (MAX_WAIT-1) with pending load-use and branch
        cyc();
        MEM_ready = 1'b0;
        ld_use_rs5();
        ID_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("wait3_c%0d", i), o, FREEZE);
            cyc();
        end
        MEM_ready = 1'b1;
        #1;
        chk("wait3_ready_lu", o, STALL);
        cyc();
        idle();
        #1;
        chk("wait3_done", o, NONE);
        chk_cnts("s2", 4, 3, 1);

        // 4-cycle wait times out
        MEM_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("wait4_c%0d", i), o, FREEZE);
            cyc();
        end
        #1;
        chk("timeout", o, TOUT);
        MEM_req = 1'b0; MEM_ready = 1'b1; ID_branch_taken = 1'b1;
        cyc();
        chk("timeout_sticky", o, TOUT);
        chk_cnts("s3", 4, 7, 1);

        reset = 1'b1;
        #1;
        chk("timeout_reset", o, NONE);
        chk_cnts("s4", 0, 0, 0);
        cyc();
        idle();
        reset = 1'b0;
        #1;
        chk("post_reset", o, NONE);

        // reset mid-wait clears the wait counter
        MEM_req = 1'b1;
        cyc();
        cyc();
        #1;
        chk("midwait", o, FREEZE);
        reset = 1'b1;
        #1;
        chk("midwait_reset", o, NONE);
        cyc();
        reset = 1'b0;
        MEM_req = 1'b0;
        #1;
        chk("midwait_release", o, NONE);
        cyc();
        MEM_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("rewait_c%0d", i), o, FREEZE);
            cyc();
        end
        MEM_ready = 1'b1;
        #1;
        chk("rewait_ready", o, NONE);
        cyc();
        idle();
        #1;
        chk("rewait_done", o, NONE);
        chk_cnts("s5", 0, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
